// File: rtl/prm_oblgc_pkg.sv
// prm_oblgc_pkg: shared sizes, FSM states and cube record for the obstacle-logic engine.
package prm_oblgc_pkg;
    localparam int IN_W  = 15;
    localparam int NCUBE = 256;
    localparam int PAR   = 4;
    localparam int AW    = $clog2(NCUBE);
    localparam int NGRP  = NCUBE / PAR;
    localparam int GW    = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int LW    = (PAR > 1) ? $clog2(PAR) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    typedef struct packed {
        logic            en;
        logic [IN_W-1:0] care;
        logic [IN_W-1:0] val;
    } cube_t;
endpackage

// File: rtl/prm_oblgc_engine_if.sv
// prm_oblgc_engine_if: config, request and result signals of the engine.
// hit_idx exists only when PRM_OBLGC_HIT_IDX_EN is defined.
interface prm_oblgc_engine_if import prm_oblgc_pkg::*;;
    logic            cfg_we;
    logic [AW-1:0]   cfg_addr;
    logic [IN_W-1:0] cfg_care;
    logic [IN_W-1:0] cfg_val;
    logic            cfg_en;
    logic            cfg_clr;
    logic            cfg_ready;
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_code;
    logic            out_valid;
    logic            out_ready;
    logic            edge_mask;
`ifdef PRM_OBLGC_HIT_IDX_EN
    logic [AW-1:0]   hit_idx;
`endif

    modport master (
        output cfg_we, cfg_addr, cfg_care, cfg_val, cfg_en, cfg_clr, in_valid, in_code, out_ready,
        input  cfg_ready, in_ready, out_valid, edge_mask
`ifdef PRM_OBLGC_HIT_IDX_EN
        , input hit_idx
`endif
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_care, cfg_val, cfg_en, cfg_clr, in_valid, in_code, out_ready,
        output cfg_ready, in_ready, out_valid, edge_mask
`ifdef PRM_OBLGC_HIT_IDX_EN
        , output hit_idx
`endif
    );
endinterface

// File: rtl/prm_cube_match.sv
// prm_cube_match: PAR parallel cube comparators with a lowest-index priority encoder.
module prm_cube_match import prm_oblgc_pkg::*; (
    input  cube_t           cubes [PAR],
    input  logic [IN_W-1:0] code,
    output logic            any_hit,
    output logic [LW-1:0]   idx
);
    always_comb begin
        any_hit = 1'b0;
        idx     = '0;
        // walk downward so the lowest matching slot is the one that sticks
        for (int i = PAR - 1; i >= 0; i--) begin
            if (cubes[i].en && (((code ^ cubes[i].val) & cubes[i].care) == '0)) begin
                any_hit = 1'b1;
                idx     = LW'(i);
            end
        end
    end
endmodule

// File: rtl/prm_oblgc_engine.sv
// prm_oblgc_engine: run-time loaded sum-of-products obstacle checker, PAR cubes per cycle, early exit.
// Define PRM_OBLGC_HIT_IDX_EN to add the hit_idx port and its register.
module prm_oblgc_engine import prm_oblgc_pkg::*; (
    input logic               clk,
    input logic               rst_n,
    prm_oblgc_engine_if.slave bus
);
    state_t           state, nxt;
    logic [GW-1:0]    g;
    logic [IN_W-1:0]  code;
    logic             mask;
    logic [NCUBE-1:0] en;
    logic [IN_W-1:0]  care [NCUBE];
    logic [IN_W-1:0]  val  [NCUBE];
    cube_t            grp  [PAR];
    logic             any_hit;
    logic [LW-1:0]    loc;
    logic [AW-1:0]    base;
    logic             idle, scan, last;

    assign idle = state == IDLE;
    assign scan = state == SCAN;
    assign last = g == GW'(NGRP - 1);
    assign base = AW'(int'(g) * PAR);

    assign bus.cfg_ready = idle;
    assign bus.in_ready  = idle;
    assign bus.out_valid = state == DONE;
    assign bus.edge_mask = mask;

    // a clear in the same cycle as a write is overridden for the written slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en <= '0;
        end else if (idle) begin
            if (bus.cfg_clr) en <= '0;
            if (bus.cfg_we) en[bus.cfg_addr] <= bus.cfg_en;
        end
    end

    always_ff @(posedge clk) begin
        if (idle && bus.cfg_we) begin
            care[bus.cfg_addr] <= bus.cfg_care;
            val[bus.cfg_addr]  <= bus.cfg_val;
        end
    end

    always_comb begin
        for (int i = 0; i < PAR; i++) begin
            grp[i] = '{en: en[base + AW'(i)], care: care[base + AW'(i)], val: val[base + AW'(i)]};
        end
    end

    prm_cube_match u_match (
        .cubes   (grp),
        .code    (code),
        .any_hit (any_hit),
        .idx     (loc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        nxt = (idle && bus.in_valid)           ? SCAN :
              (scan && (any_hit || last))      ? DONE :
              (state == DONE && bus.out_ready) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g    <= '0;
            code <= '0;
            mask <= 1'b0;
        end else if (idle && bus.in_valid) begin
            code <= bus.in_code;
            g    <= '0;
        end else if (scan) begin
            if (any_hit)   mask <= 1'b1;
            else if (last) mask <= 1'b0;
            else           g    <= g + 1'b1;
        end
    end

`ifdef PRM_OBLGC_HIT_IDX_EN
    logic [AW-1:0] hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit <= '0;
        end else if (scan) begin
            if (any_hit)   hit <= base + AW'(loc);
            else if (last) hit <= '0;
        end
    end

    assign bus.hit_idx = hit;
`endif
endmodule

// File: tb/tb_prm_oblgc_engine.sv
// tb_prm_oblgc_engine: directed and randomized checks against a first-match table model.
module tb_prm_oblgc_engine;
    import prm_oblgc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prm_oblgc_engine_if bus ();
    prm_oblgc_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int n_cmp = 0;
    int n_bad = 0;
    bit              m_en   [NCUBE];
    logic [IN_W-1:0] m_care [NCUBE];
    logic [IN_W-1:0] m_val  [NCUBE];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int first_hit(logic [IN_W-1:0] c);
        for (int k = 0; k < NCUBE; k++)
            if (m_en[k] && ((c ^ m_val[k]) & m_care[k]) == 0) return k;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_model();
        for (int k = 0; k < NCUBE; k++) m_en[k] = 1'b0;
    endtask

    task automatic wr(int a, logic [IN_W-1:0] care, logic [IN_W-1:0] val, bit en);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(a);
        bus.cfg_care = care;
        bus.cfg_val  = val;
        bus.cfg_en   = en;
        tick();
        bus.cfg_we   = 1'b0;
        m_care[a] = care;
        m_val[a]  = val;
        m_en[a]   = en;
    endtask

    task automatic clr();
        bus.cfg_clr = 1'b1;
        tick();
        bus.cfg_clr = 1'b0;
        clr_model();
    endtask

    // issues one request; a hold window exercises backpressure and a dropped table write
    task automatic req(string tag, logic [IN_W-1:0] c, int hold);
        int h, exp_lat, lat;
        h = first_hit(c);
        exp_lat = (h < 0) ? NGRP : h / PAR + 1;
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 1);
        bus.in_code  = c;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b0;
        bus.cfg_clr  = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < NGRP + 8) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_edge_mask"}, 32'(bus.edge_mask), 32'(h >= 0));
`ifdef PRM_OBLGC_HIT_IDX_EN
        chk({tag, "_hit_idx"}, 32'(bus.hit_idx), (h < 0) ? 0 : 32'(h));
`endif
        if (hold > 0) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = AW'((h < 0) ? 0 : h);
            bus.cfg_care = '1;
            bus.cfg_val  = ~c;
            bus.cfg_en   = 1'b0;
            bus.cfg_clr  = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_valid"}, 32'(bus.out_valid), 1);
            chk({tag, "_hold_mask"}, 32'(bus.edge_mask), 32'(h >= 0));
            chk({tag, "_hold_in_ready"}, 32'(bus.in_ready), 0);
`ifdef PRM_OBLGC_HIT_IDX_EN
            chk({tag, "_hold_hit_idx"}, 32'(bus.hit_idx), (h < 0) ? 0 : 32'(h));
`endif
        end
        bus.cfg_we  = 1'b0;
        bus.cfg_clr = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(bus.out_valid), 0);
        chk({tag, "_ready_back"}, 32'(bus.in_ready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a;
        logic [IN_W-1:0] c;
        bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_care = '0; bus.cfg_val = '0;
        bus.cfg_en = 0; bus.cfg_clr = 0; bus.in_valid = 0; bus.in_code = '0; bus.out_ready = 0;
        clr_model();
        for (int k = 0; k < NCUBE; k++) begin
            m_care[k] = '0;
            m_val[k]  = '0;
        end
        repeat (3) tick();
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_edge_mask", 32'(bus.edge_mask), 0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_cfg_ready", 32'(bus.cfg_ready), 1);

        req("empty", 15'h1234, 0);

        wr(0, 15'h7FFF, 15'h0A5A, 1'b1);
        req("slot0_hit", 15'h0A5A, 0);
        req("slot0_miss", 15'h0A5B, 0);

        wr(9, 15'h4000, 15'h4000, 1'b1);
        wr(13, 15'h4000, 15'h4000, 1'b1);
        req("first_of_two", 15'h4000, 10);
        req("after_hold", 15'h4000, 0);

        for (int k = 1; k <= 4; k++) wr(k, 15'h0000, 15'h0000, 1'b1);
        req("low_any", 15'h1111, 0);
        bus.cfg_clr  = 1'b1;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(5);
        bus.cfg_care = '0;
        bus.cfg_val  = '0;
        bus.cfg_en   = 1'b1;
        clr_model();
        m_care[5] = '0;
        m_val[5]  = '0;
        m_en[5]   = 1'b1;
        req("clr_we", 15'h0A5A, 0);
        req("after_clr", 15'h4000, 0);

        clr();
        wr(200, 15'h0000, 15'h0000, 1'b1);
        bus.in_code  = '0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        chk("scan_no_valid", 32'(bus.out_valid), 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 0);
        chk("midrst_mask", 32'(bus.edge_mask), 0);
        clr_model();
        tick();
        rst_n = 1'b1;
        tick();
        req("post_rst", 15'h0000, 0);

        for (int it = 0; it < 30; it++) begin
            repeat ($urandom_range(1, 5)) begin
                a = $urandom_range(0, NCUBE - 1);
                wr(a, IN_W'($urandom & $urandom), IN_W'($urandom), ($urandom % 4) != 0);
            end
            if ($urandom % 10 == 0) clr();
            a = $urandom_range(0, NCUBE - 1);
            c = ($urandom % 2 == 0) ? (m_val[a] ^ IN_W'(1 << $urandom_range(0, IN_W - 1))) : IN_W'($urandom);
            req("rnd", c, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
